// File: rtl/wb_sram_slave_if.sv
// wb_sram_slave_if: Wishbone B4 bus bundle between a master and the SRAM slave
interface wb_sram_slave_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [2:0]                 CTI;
  logic [1:0]                 BTE;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH-1:0]   DAT_R;
  logic                       CYC;
  logic                       STB;
  logic                       WE;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       ACK;
  logic                       ERR;
  modport master (output ADR, CTI, BTE, DAT_W, CYC, STB, WE, SEL, input DAT_R, ACK, ERR);
  modport slave (input ADR, CTI, BTE, DAT_W, CYC, STB, WE, SEL, output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B4 SRAM responder (classic + CTI/BTE bursts); define WB_SRAM_SLAVE_ERR_EN for out-of-range ERR
module wb_sram_slave #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       DEPTH         = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0
) (
  input logic            clk,
  input logic            rstn,
  wb_sram_slave_if.slave bus
);
  localparam int BW = WB_DATA_WIDTH / 8;
  localparam int BB = $clog2(BW);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;
  state_t                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [1:0]               bte_q, bte_d;
  logic                     oob_q, oob_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;
  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];
  logic [WB_ADDR_WIDTH-1:0] offset;
  logic [AW-1:0]            req_idx, next_addr, wrap_mask, mem_idx;
  logic                     req_oob, next_oob, mem_we;
  assign offset    = bus.ADR - ADDR_BASE;
  assign req_idx   = AW'(offset >> BB);
  assign wrap_mask = bte_q == 2'b01 ? AW'(3) : bte_q == 2'b10 ? AW'(7) : bte_q == 2'b11 ? AW'(15) : '1;
  assign next_addr = (addr_q & ~wrap_mask) | ((addr_q + AW'(1)) & wrap_mask);
`ifdef WB_SRAM_SLAVE_ERR_EN
  assign req_oob  = (offset >> (AW + BB)) != '0;
  assign next_oob = oob_q | (bte_q == 2'b00 && addr_q == '1);
`else
  assign req_oob  = 1'b0;
  assign next_oob = 1'b0;
`endif
  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.DAT_R = dat_r_q;
  // Next-state, response and memory-port control; responses are registered one edge ahead of the beat
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bte_d   = bte_q;
    oob_d   = oob_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_r_d = dat_r_q;
    mem_we  = 1'b0;
    mem_idx = addr_q;
    if (!bus.CYC) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.STB) begin
            addr_d  = req_idx;
            bte_d   = bus.BTE;
            oob_d   = req_oob;
            state_d = bus.CTI == 3'b010 ? BURST : SINGLE;
            ack_d   = !req_oob;
            err_d   = req_oob;
            dat_r_d = req_oob ? '0 : mem[req_idx];
            mem_we  = bus.WE && !req_oob && bus.CTI != 3'b010;
            mem_idx = req_idx;
          end
        end
        SINGLE: state_d = IDLE;
        BURST: begin
          if (bus.STB && (ack_q || err_q)) begin
            mem_we = bus.WE && !oob_q;
            if (bus.CTI == 3'b010) begin
              addr_d  = next_addr;
              oob_d   = next_oob;
              ack_d   = !next_oob;
              err_d   = next_oob;
              dat_r_d = next_oob ? '0 : mem[next_addr];
            end else begin
              state_d = IDLE;
            end
          end else if (bus.STB) begin
            ack_d   = !oob_q;
            err_d   = oob_q;
            dat_r_d = oob_q ? '0 : mem[addr_q];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Control and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bte_q   <= '0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bte_q   <= bte_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
    end
  end
  // Byte-lane write port; contents are kept across reset
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < BW; i++)
        if (bus.SEL[i]) mem[mem_idx][i*8 +: 8] <= bus.DAT_W[i*8 +: 8];
  end
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: randomized Wishbone master with a word-array reference model of the SRAM slave
module tb_wb_sram_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000;
`ifdef WB_SRAM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef struct {int idx; bit oob;} exp_t;
  logic        clk, rstn;
  logic [31:0] wbuf [64];
  logic [3:0]  sbuf [64];
  logic [31:0] rbuf [64];
  logic        rerr [64];
  logic [31:0] mdl [DEPTH];
  exp_t        q [$];
  int          lat, idle_c;
  int          vectors = 0;
  int          miscompares = 0;
  wb_sram_slave_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();
  wb_sram_slave #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  function automatic void beat_idx(input logic [31:0] adr, input logic [1:0] bte, input int k, output int idx, output bit oob);
    logic [31:0] off;
    int s, m, lin;
    bit soob;
    off  = adr - BASE;
    s    = int'((off >> 2) % DEPTH);
    soob = ERR_EN && (adr < BASE || off >= 32'(DEPTH * 4));
    m    = bte == 2'd1 ? 4 : bte == 2'd2 ? 8 : bte == 2'd3 ? 16 : 0;
    lin  = m == 0 ? s + k : (s / m) * m + (s % m + k) % m;
    idx  = lin % DEPTH;
    oob  = soob || (ERR_EN && m == 0 && lin >= DEPTH);
  endfunction
  task automatic drive_beat(input int k, input int n);
    bus.DAT_W = wbuf[k];
    bus.SEL   = sbuf[k];
    bus.CTI   = n == 1 ? 3'b000 : k == n - 1 ? 3'b111 : 3'b010;
  endtask
  task automatic xfer(input logic [31:0] adr, input logic [1:0] bte, input int n, input logic we,
                      input int gap_at, input int gap_len, input int abort_at);
    int  idx, k, guard;
    bit  oob;
    for (int j = 0; j < n; j++) begin
      beat_idx(adr, bte, j, idx, oob);
      q.push_back('{idx: idx, oob: oob});
    end
    k = 0; guard = 0; lat = 0; idle_c = 0;
    @(posedge clk); #1;
    bus.ADR = adr; bus.BTE = bte; bus.WE = we; bus.CYC = 1'b1; bus.STB = 1'b1;
    drive_beat(0, n);
    while (k < n && k != abort_at) begin
      @(negedge clk);
      if (bus.STB && (bus.ACK || bus.ERR)) begin
        rbuf[k] = bus.DAT_R;
        rerr[k] = bus.ERR;
        k++;
        @(posedge clk); #1;
        if (k == gap_at) begin
          bus.STB = 1'b0;
          repeat (gap_len) begin
            @(negedge clk);
            if (!bus.ACK && !bus.ERR) idle_c++;
            @(posedge clk); #1;
          end
          bus.STB = 1'b1;
        end
        if (k < n) drive_beat(k, n);
      end else begin
        if (k == 0) lat++; else idle_c++;
        guard++;
        if (guard > 40) begin
          chk("beat_timeout", k, n);
          break;
        end
      end
    end
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
    if (k < n) begin
      q.delete();
      @(negedge clk);
    end
    @(negedge clk);
    chk("resp_drop", {bus.ACK, bus.ERR}, 2'b00);
  endtask
  task automatic wr1(input int idx, input logic [31:0] d, input logic [3:0] s);
    wbuf[0] = d; sbuf[0] = s;
    xfer(BASE + (32'(idx) << 2), 2'd0, 1, 1'b1, -1, 0, 99);
    chk("single_latency", lat, 1);
  endtask
  task automatic rd1(input int idx);
    xfer(BASE + (32'(idx) << 2), 2'd0, 1, 1'b0, -1, 0, 99);
    chk("single_latency", lat, 1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.CYC && bus.STB && (bus.ACK || bus.ERR)) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("resp_ack", bus.ACK, !e.oob);
          chk("resp_err", bus.ERR, e.oob);
          if (!bus.WE) chk("dat_r", bus.DAT_R, e.oob ? 32'h0 : mdl[e.idx]);
          else if (!e.oob)
            for (int b = 0; b < 4; b++)
              if (bus.SEL[b]) mdl[e.idx][b*8 +: 8] = bus.DAT_W[b*8 +: 8];
        end
      end
    end
  end
  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.ADR = '0; bus.CTI = '0; bus.BTE = '0;
    bus.DAT_W = '0; bus.SEL = '0;
    rstn = 1'b0;
    #23;
    chk("reset_state", {bus.ACK, bus.ERR, bus.DAT_R}, 34'h0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      wbuf[j] = $urandom;
      sbuf[j] = 4'hF;
    end
    xfer(BASE, 2'd0, DEPTH, 1'b1, -1, 0, 99);
    chk("preload_latency", lat, 1);
    chk("preload_ack_gap", idle_c, 0);
    wr1(4, 32'hFFFF_FFFF, 4'hF);
    wr1(4, 32'hA5A5_5A5A, 4'b0101);
    rd1(4);
    chk("sel_merge", rbuf[0], 32'hFFA5_FF5A);
    for (int j = 0; j < 4; j++) wr1(8 + j, 32'h80 + 32'(j), 4'hF);
    wr1(3, 32'h33, 4'hF);
    xfer(BASE + 32'd32, 2'd0, 4, 1'b0, -1, 0, 99);
    chk("lin_latency", lat, 1);
    chk("lin_ack_gap", idle_c, 0);
    for (int j = 0; j < 4; j++) chk("lin_data", rbuf[j], 32'h80 + 32'(j));
    for (int j = 0; j < 4; j++) begin
      wbuf[j] = 32'(j + 1);
      sbuf[j] = 4'hF;
    end
    xfer(BASE + 32'd24, 2'd1, 4, 1'b1, -1, 0, 99);
    begin
      logic [31:0] wrap_exp [6];
      wrap_exp = '{32'h33, 32'h3, 32'h4, 32'h1, 32'h2, 32'h80};
      for (int j = 0; j < 6; j++) begin
        rd1(3 + j);
        chk("wrap4_data", rbuf[0], wrap_exp[j]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      wbuf[j] = 32'hB0 + 32'(j);
      sbuf[j] = 4'hF;
    end
    xfer(BASE + 32'd80, 2'd0, 4, 1'b1, 2, 2, 99);
    chk("stb_gap_ack_low", idle_c, 2);
    xfer(BASE + 32'd80, 2'd0, 4, 1'b0, -1, 0, 99);
    for (int j = 0; j < 4; j++) chk("stb_gap_data", rbuf[j], 32'hB0 + 32'(j));
    wr1(0, 32'hC0C0_0000, 4'hF);
    rd1(DEPTH);
    chk("oob_err", rerr[0], ERR_EN);
    chk("oob_data", rbuf[0], ERR_EN ? 32'h0 : 32'hC0C0_0000);
    q.delete();
    for (int j = 0; j < 8; j++) begin
      int idx;
      bit oob;
      beat_idx(BASE + 32'd32, 2'd0, j, idx, oob);
      q.push_back('{idx: idx, oob: oob});
    end
    @(posedge clk); #1;
    bus.ADR = BASE + 32'd32; bus.BTE = 2'd0; bus.WE = 1'b0; bus.CTI = 3'b010; bus.CYC = 1'b1; bus.STB = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ack_before_reset", bus.ACK, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset", {bus.ACK, bus.ERR, bus.DAT_R}, 34'h0);
    bus.CYC = 1'b0; bus.STB = 1'b0;
    q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    rd1(20);
    chk("read_after_reset", rbuf[0], 32'hB0);
    for (int t = 0; t < 300; t++) begin
      int n, r, ga, gl, ab;
      logic [31:0] adr;
      logic [1:0]  bte;
      logic        we;
      r   = $urandom_range(0, 19);
      adr = r == 0 ? BASE - (32'($urandom_range(1, 8)) << 2)
          : r == 1 ? BASE + (32'($urandom_range(DEPTH, DEPTH + 4)) << 2)
          : BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(0, 3));
      n   = $urandom_range(1, 8);
      bte = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) begin
        wbuf[j] = $urandom;
        sbuf[j] = 4'($urandom_range(0, 15));
      end
      r  = $urandom_range(0, 3);
      ga = (r == 1 && n > 1) ? $urandom_range(1, n - 1) : -1;
      gl = $urandom_range(1, 3);
      ab = (r == 2 && n > 1) ? $urandom_range(1, n - 1) : 99;
      xfer(adr, bte, n, we, ga, gl, ab);
      chk("first_latency", lat, 1);
      if (ab == 99) chk("ack_gap", idle_c, ga > 0 ? gl : 0);
    end
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
